// File: rtl/sipo.sv
// Serial-to-parallel packer: MSB-first symbol collector feeding a one-word
// holding register in front of the output FIFO. Partial-word flush via SIPO_FLUSH_EN.
module sipo #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned SYM_W  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [SYM_W-1:0]  sym_i,
  input  logic              sym_valid_i,
  input  logic              flush_i,
  input  logic              clr_ovf_i,
  input  logic              fifo_full_i,
  output logic              fifo_wr_en_o,
  output logic [DATA_W-1:0] fifo_data_o,
  output logic              overflow_o,
  output logic              busy_o
);

  localparam int unsigned N     = DATA_W / SYM_W;
  localparam int unsigned CNT_W = $clog2(N) + 1;

  typedef enum logic {
    HOLD_EMPTY = 1'b0,
    HOLD_FULL  = 1'b1
  } hold_state_t;

  hold_state_t       state_q, state_d;
  logic [DATA_W-1:0] sr_q, sr_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic [DATA_W-1:0] word_c;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_acc;
  logic              ovf_q, ovf_d, ovf_set;
  logic              full_evt, flush_evt, word_evt;

  // Collector: shift in the symbol, count accepted symbols (may reach N)
  always_comb begin
    sr_d    = sr_q;
    cnt_acc = cnt_q;
    if (sym_valid_i) begin
      sr_d    = {sr_q[DATA_W-SYM_W-1:0], sym_i};
      cnt_acc = cnt_q + CNT_W'(1);
    end
  end

  assign full_evt = (cnt_acc == CNT_W'(N));

`ifdef SIPO_FLUSH_EN
  logic [31:0] pad_bits;

  // A flush closes whatever has been accepted, including this cycle's symbol
  assign flush_evt = flush_i && (cnt_acc != '0);
  assign pad_bits  = 32'(SYM_W) * (32'(N) - 32'(cnt_acc));
  assign word_c    = sr_d << pad_bits;
`else
  logic unused_flush;

  assign unused_flush = flush_i;
  assign flush_evt    = 1'b0;
  assign word_c       = sr_d;
`endif

  assign word_evt = full_evt | flush_evt;
  assign cnt_d    = word_evt ? '0 : cnt_acc;

  assign fifo_wr_en_o = (state_q == HOLD_FULL) & ~fifo_full_i;

  // Hold stage next-state: refill on drain, drop new word when stalled
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    ovf_set = 1'b0;
    case (state_q)
      HOLD_EMPTY: begin
        if (word_evt) begin
          state_d = HOLD_FULL;
          hold_d  = word_c;
        end
      end
      HOLD_FULL: begin
        if (fifo_wr_en_o) begin
          if (word_evt) hold_d  = word_c;
          else          state_d = HOLD_EMPTY;
        end else if (word_evt) begin
          ovf_set = 1'b1;
        end
      end
    endcase
    ovf_d = ovf_set | (ovf_q & ~clr_ovf_i);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= HOLD_EMPTY;
      sr_q    <= '0;
      cnt_q   <= '0;
      hold_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      ovf_q   <= ovf_d;
    end
  end

  assign fifo_data_o = hold_q;
  assign overflow_o  = ovf_q;
  assign busy_o      = (cnt_q != '0) | (state_q == HOLD_FULL);

endmodule
